// File: rtl/simon_stream_ctrl.sv
// Valid/ready block-stream sequencer in front of a single SIMON_64128 core.
// Define SIMON_CBC_EN to add CBC chaining (iv_load/iv_in ports); ECB otherwise.
module simon_stream_ctrl #(
    parameter int N  = 32,
    parameter int M  = 4,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              nR,
`ifdef SIMON_CBC_EN
    input  logic              iv_load,
    input  logic [2*N-1:0]    iv_in,
`endif
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [M*N-1:0]    key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*N-1:0]    in_data,
    input  logic              in_enc_dec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*N-1:0]    out_data,
    output logic              busy,
    output logic [CW-1:0]     blk_count,
    output logic              newKey,
    output logic              newData,
    output logic              enc_dec,
    output logic              readData,
    output logic [2*N-1:0]    plain,
    output logic [M*N-1:0]    key,
    input  logic              ldKey,
    input  logic              doneKey,
    input  logic              ldData,
    input  logic              doneData,
    input  logic [2*N-1:0]    cipher
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_KREQ  = 3'd1;
    localparam logic [2:0] S_KWAIT = 3'd2;
    localparam logic [2:0] S_DREQ  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    logic [2:0]     state_q, state_d;
    logic           key_loaded_q, key_loaded_d;
    logic [M*N-1:0] key_q, key_d;
    logic [2*N-1:0] plain_q, plain_d;
    logic           enc_dec_q, enc_dec_d;
    logic [2*N-1:0] out_data_q, out_data_d;
    logic [CW-1:0]  blk_count_q, blk_count_d;
    logic [2*N-1:0] iv_val;
    logic           hold_off;
    logic           idle;
    logic           key_acc;
    logic           blk_acc;

`ifdef SIMON_CBC_EN
    logic [2*N-1:0] iv_q, iv_d;
    assign iv_val   = iv_q;
    assign hold_off = iv_load;
`else
    assign iv_val   = '0;
    assign hold_off = 1'b0;
`endif

    assign idle      = (state_q == S_IDLE);
    // An IV load in IDLE takes the cycle; neither stream is accepted alongside it.
    assign key_ready = idle && !hold_off;
    assign in_ready  = idle && !hold_off && key_loaded_q && !key_valid;
    assign key_acc   = key_valid && key_ready;
    assign blk_acc   = in_valid && in_ready;

    assign newKey    = (state_q == S_KREQ);
    assign newData   = (state_q == S_DREQ);
    assign readData  = (state_q == S_ACK);
    assign out_valid = (state_q == S_OUT);
    assign busy      = !idle;
    assign enc_dec   = enc_dec_q;
    assign plain     = plain_q;
    assign key       = key_q;
    assign out_data  = out_data_q;
    assign blk_count = blk_count_q;

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d      = state_q;
        key_loaded_d = key_loaded_q;
        key_d        = key_q;
        plain_d      = plain_q;
        enc_dec_d    = enc_dec_q;
        out_data_d   = out_data_q;
        blk_count_d  = blk_count_q;
`ifdef SIMON_CBC_EN
        iv_d         = iv_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef SIMON_CBC_EN
                if (iv_load) iv_d = iv_in;
`endif
                if (key_acc) begin
                    key_d        = key_in;
                    key_loaded_d = 1'b0;
                    blk_count_d  = '0;
`ifdef SIMON_CBC_EN
                    iv_d         = '0;
`endif
                    state_d      = S_KREQ;
                end else if (blk_acc) begin
                    plain_d   = in_enc_dec ? (in_data ^ iv_val) : in_data;
                    enc_dec_d = in_enc_dec;
                    state_d   = S_DREQ;
                end
            end
            S_KREQ:  if (ldKey) state_d = S_KWAIT;
            S_KWAIT: begin
                if (doneKey) begin
                    key_loaded_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_DREQ:  if (ldData) state_d = S_RUN;
            S_RUN: begin
                // The core only guarantees cipher while doneData is high, so capture here.
                if (doneData) begin
                    out_data_d = enc_dec_q ? cipher : (cipher ^ iv_val);
                    state_d    = S_ACK;
                end
            end
            S_ACK:   if (!doneData) state_d = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    blk_count_d = blk_count_q + 1'b1;
`ifdef SIMON_CBC_EN
                    // Chain on ciphertext: our output when encrypting, our input when decrypting.
                    iv_d        = enc_dec_q ? out_data_q : plain_q;
`endif
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
        if (!nR) begin
            state_q      <= S_IDLE;
            key_loaded_q <= 1'b0;
            key_q        <= '0;
            plain_q      <= '0;
            enc_dec_q    <= 1'b0;
            out_data_q   <= '0;
            blk_count_q  <= '0;
`ifdef SIMON_CBC_EN
            iv_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            key_loaded_q <= key_loaded_d;
            key_q        <= key_d;
            plain_q      <= plain_d;
            enc_dec_q    <= enc_dec_d;
            out_data_q   <= out_data_d;
            blk_count_q  <= blk_count_d;
`ifdef SIMON_CBC_EN
            iv_q         <= iv_d;
`endif
        end
    end

endmodule

// File: tb/tb_simon_stream_ctrl.sv
// Bench for simon_stream_ctrl: behavioural SIMON_64128 core, table of blocks, scoreboard queue.
// Exercises CBC chaining as well when SIMON_CBC_EN is defined.
module tb_simon_stream_ctrl;

    localparam int N  = 32;
    localparam int M  = 4;
    localparam int CW = 16;
    localparam logic [127:0] KEY  = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [127:0] KEY2 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [63:0]  PT   = 64'h656b696c20646e75;
    localparam logic [63:0]  CT   = 64'h44c8fc20b9dfa07a;

    logic           clk;
    logic           nR;
`ifdef SIMON_CBC_EN
    logic           iv_load;
    logic [63:0]    iv_in;
`endif
    logic           key_valid, key_ready;
    logic [127:0]   key_in;
    logic           in_valid, in_ready;
    logic [63:0]    in_data;
    logic           in_enc_dec;
    logic           out_valid, out_ready;
    logic [63:0]    out_data;
    logic           busy;
    logic [CW-1:0]  blk_count;
    logic           newKey, newData, enc_dec, readData;
    logic [63:0]    plain;
    logic [127:0]   key;
    logic           ldKey, doneKey, ldData, doneData;
    logic [63:0]    cipher;

    simon_stream_ctrl #(.N(N), .M(M), .CW(CW)) dut (
        .clk(clk), .nR(nR),
`ifdef SIMON_CBC_EN
        .iv_load(iv_load), .iv_in(iv_in),
`endif
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_enc_dec(in_enc_dec),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .blk_count(blk_count),
        .newKey(newKey), .newData(newData), .enc_dec(enc_dec), .readData(readData),
        .plain(plain), .key(key),
        .ldKey(ldKey), .doneKey(doneKey), .ldData(ldData), .doneData(doneData), .cipher(cipher)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  rx_log[$];
    logic [127:0] tb_key;
    logic [63:0]  tb_iv;
    logic         rand_ready;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    function automatic logic [31:0] simon_f(input logic [31:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    // Reference SIMON 64/128: 44 rounds, z3 constant sequence, word 0 of the key in bits [31:0].
    function automatic logic [63:0] simon_crypt(input logic [127:0] k_in, input logic [63:0] blk,
                                                input logic enc);
        logic [31:0] k [44];
        logic [31:0] x, y, t;
        logic [0:61] z;
        z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        for (int i = 0; i < 4; i++) k[i] = k_in[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = ror(k[i-1], 3) ^ k[i-3];
            t = t ^ ror(t, 1);
            k[i] = ~k[i-4] ^ t ^ {31'b0, z[i-4]} ^ 32'd3;
        end
        x = blk[63:32];
        y = blk[31:0];
        if (enc) begin
            for (int i = 0; i < 44; i++) begin
                t = x; x = y ^ simon_f(x) ^ k[i]; y = t;
            end
        end else begin
            for (int i = 43; i >= 0; i--) begin
                t = y; y = x ^ simon_f(y) ^ k[i]; x = t;
            end
        end
        return {x, y};
    endfunction

    // Expected result of the next accepted block, tracking the chaining value in CBC builds.
    function automatic logic [63:0] expect_blk(input logic enc, input logic [63:0] din);
        logic [63:0] r;
`ifdef SIMON_CBC_EN
        if (enc) begin
            r = simon_crypt(tb_key, din ^ tb_iv, 1'b1);
            tb_iv = r;
        end else begin
            r = simon_crypt(tb_key, din, 1'b0) ^ tb_iv;
            tb_iv = din;
        end
`else
        r = simon_crypt(tb_key, din, enc);
`endif
        return r;
    endfunction

    // Behavioural core: ldKey/ldData one cycle after the request, done after a short delay.
    logic [127:0] m_key;
    logic [63:0]  m_res;
    int           m_ks, m_ds, m_kcnt, m_dcnt;
    int           key_done_cnt;
    logic         m_rst;

    initial begin
        ldKey = 0; doneKey = 0; ldData = 0; doneData = 0; cipher = '0;
        m_key = '0; m_res = '0; m_ks = 0; m_ds = 0; m_kcnt = 0; m_dcnt = 0; key_done_cnt = 0;
        forever begin
            @(posedge clk);
            m_rst = !nR;
            #1;
            if (m_rst) begin
                ldKey = 0; doneKey = 0; ldData = 0; doneData = 0; cipher = '0;
                m_ks = 0; m_ds = 0;
            end else begin
                case (m_ks)
                    0: if (newKey) begin
                        m_key = key; ldKey = 1; m_kcnt = 3; m_ks = 1;
                    end
                    1: begin
                        ldKey = 0;
                        if (m_kcnt == 0) begin doneKey = 1; m_ks = 2; key_done_cnt++; end
                        else m_kcnt--;
                    end
                    default: begin doneKey = 0; m_ks = 0; end
                endcase
                case (m_ds)
                    0: if (newData) begin
                        m_res = simon_crypt(m_key, plain, enc_dec);
                        ldData = 1; m_dcnt = $urandom_range(2, 5); m_ds = 1;
                    end
                    1: begin
                        ldData = 0;
                        if (m_dcnt == 0) begin doneData = 1; cipher = m_res; m_ds = 2; end
                        else m_dcnt--;
                    end
                    default: if (readData) begin
                        doneData = 0; cipher = ~m_res; m_ds = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each handshake, checks stability while stalled.
    initial begin
        logic        stalled;
        logic [63:0] held;
        stalled = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!nR) stalled = 0;
            else if (out_valid) begin
                if (stalled) check("out_data_stable", out_data, held);
                if (out_ready) begin
                    stalled = 0;
                    rx_log.push_back(out_data);
                    if (exp_q.size() == 0) check("unexpected_output", out_data, 0);
                    else check("out_data", out_data, exp_q.pop_front());
                end else begin
                    stalled = 1;
                    held = out_data;
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_key(input logic [127:0] k);
        logic acc;
        acc = 0;
        key_in = k;
        key_valid = 1;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            acc = key_ready;
            @(posedge clk);
            #1;
        end
        key_valid = 0;
        check("key_accept", acc, 1);
        tb_key = k;
        tb_iv = '0;
    endtask

    task automatic send_block(input logic enc, input logic [63:0] din,
                              input logic use_lit, input logic [63:0] lit);
        logic acc;
        logic [63:0] e;
        acc = 0;
        in_data = din;
        in_enc_dec = enc;
        in_valid = 1;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        check("in_accept", acc, 1);
        if (acc) begin
            e = expect_blk(enc, din);
            exp_q.push_back(use_lit ? lit : e);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 1000 && exp_q.size() != 0; c++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run();
        logic seen;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = (m_ds == 1);
        end
        check("reach_run", seen, 1);
    endtask

    typedef struct {
        logic        reload;
        logic        enc;
        logic [63:0] din;
        logic        use_lit;
        logic [63:0] lit;
        logic        rnd;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic hs, bad;
        logic [63:0] c1, c2;

        vecs[0] = '{1'b1, 1'b1, PT, 1'b1, CT, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b0, CT, 1'b1, PT, 1'b0, 1};
        vecs[2] = '{1'b1, 1'b1, 64'ha8d5f7de0123fedc, 1'b0, 64'h0, 1'b1, -1};
        vecs[3] = '{1'b0, 1'b1, 64'hb9e608ef1234edcb, 1'b0, 64'h0, 1'b1, -1};
        vecs[4] = '{1'b0, 1'b1, 64'hcaf719f02345dcba, 1'b0, 64'h0, 1'b1, -1};
        vecs[5] = '{1'b0, 1'b1, 64'hdb082a013456cba9, 1'b0, 64'h0, 1'b1, -1};
        vecs[6] = '{1'b0, 1'b1, 64'h567f11decdef3210, 1'b0, 64'h0, 1'b1, 5};

        nR = 0; key_valid = 0; in_valid = 0; key_in = '0; in_data = '0; in_enc_dec = 0;
        rand_ready = 0; tb_key = '0; tb_iv = '0;
`ifdef SIMON_CBC_EN
        iv_load = 0; iv_in = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_key_ready", key_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_newKey", newKey, 0);
        @(posedge clk);
        #1;
        nR = 1;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].reload) send_key(KEY);
            rand_ready = vecs[i].rnd;
            send_block(vecs[i].enc, vecs[i].din, vecs[i].use_lit, vecs[i].lit);
            if (vecs[i].exp_cnt >= 0) begin
                drain();
                check("blk_count", blk_count, vecs[i].exp_cnt);
            end
        end
        rand_ready = 0;

        // Simultaneous key and block: key first, block only after doneKey.
        hs = (key_done_cnt != 0);
        c1 = 64'(key_done_cnt);
        key_in = KEY2; key_valid = 1;
        in_data = PT; in_enc_dec = 1; in_valid = 1;
        @(negedge clk);
        check("both_key_ready", key_ready, 1);
        check("both_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        key_valid = 0;
        tb_key = KEY2;
        tb_iv = '0;
        in_valid = 0;
        send_block(1'b1, PT, 1'b0, 64'h0);
        check("blk_after_doneKey", 64'(key_done_cnt) > c1, 1);

        // Key request while a block is in flight waits for the output handshake.
        wait_run();
        key_in = KEY; key_valid = 1;
        hs = 0; bad = 0;
        for (int c = 0; c < 300 && !hs; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs = 1;
            else if (key_ready) bad = 1;
            @(posedge clk);
            #1;
        end
        check("run_handshake", hs, 1);
        check("key_ready_low_in_flight", bad, 0);
        check("key_ready_after_out", key_ready, 1);
        @(posedge clk);
        #1;
        key_valid = 0;
        tb_key = KEY;
        tb_iv = '0;
        send_block(1'b0, CT, 1'b1, PT);
        drain();

        // Reset in the middle of a block.
        send_block(1'b1, PT, 1'b0, 64'h0);
        wait_run();
        nR = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.delete();
        tb_iv = '0;
        check("mid_rst_key_ready", key_ready, 1);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_blk_count", blk_count, 0);
        check("mid_rst_plain", plain, 0);
        check("mid_rst_key", key, 0);
        check("mid_rst_ctrl", {newKey, newData, readData, enc_dec}, 0);
        nR = 1;
        send_key(KEY);
        send_block(1'b1, PT, 1'b1, CT);
        drain();

`ifdef SIMON_CBC_EN
        // CBC: identical plaintexts chain to distinct ciphertexts and decrypt back.
        send_key(KEY);
        hs = 0;
        for (int c = 0; c < 100 && !hs; c++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
        end
        check("cbc_idle", hs, 1);
        iv_load = 1; iv_in = '0;
        @(posedge clk);
        #1;
        iv_load = 0;
        tb_iv = '0;
        rx_log.delete();
        send_block(1'b1, PT, 1'b0, 64'h0);
        send_block(1'b1, PT, 1'b0, 64'h0);
        drain();
        check("cbc_rx_count", rx_log.size(), 2);
        c1 = rx_log[0];
        c2 = rx_log[1];
        check("cbc_c1", c1, CT);
        check("cbc_c2_ne_c1", c2 != c1, 1);
        iv_load = 1; iv_in = '0;
        @(posedge clk);
        #1;
        iv_load = 0;
        tb_iv = '0;
        send_block(1'b0, c1, 1'b1, PT);
        send_block(1'b0, c2, 1'b1, PT);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
